// File: rtl/chan_arb_mux.sv
// N-channel arbitrating mux with a registered output stage. A round-robin or fixed-priority
// arbiter picks the source, and an optional burst lock keeps the grant on one channel for up to BURST beats.
module chan_arb_mux #(
    parameter int WIDTH    = 8,
    parameter int NCH      = 2,
    parameter int ARB_MODE = 0,
    parameter int BURST    = 1,
    localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic [NCH-1:0]       in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [CHW-1:0]       out_ch,
    input  logic                 out_ready,
    output logic                 dbg_state
);

    localparam int CNTW = (BURST > 1) ? $clog2(BURST) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t           state, state_nxt;
    logic [CHW-1:0]   rr_ptr, rr_nxt;
    logic [CHW-1:0]   lock_ch, lock_nxt;
    logic [CNTW-1:0]  burst_cnt, cnt_nxt;
    logic [CHW-1:0]   grant;
    logic             grant_vld;
    logic             can_load;
    logic             accept;
    logic [WIDTH-1:0] sel_data;
    int               cand;

    assign dbg_state = (state == LOCKED);
    assign can_load  = !out_valid || out_ready;

    // Handshake: a beat moves on a port in any cycle where valid and ready are both high.
    // in_ready never depends on the port's own in_valid beyond arbitration, and sources
    // must hold in_valid independent of in_ready.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        cand      = 0;
        if (state == LOCKED) begin
            grant     = lock_ch;
            grant_vld = 1'b1;
        end else begin
            // Walk candidates from the lowest search priority upward so the last hit wins.
            for (int k = NCH - 1; k >= 0; k--) begin
                cand = (ARB_MODE == 1) ? k : (int'(rr_ptr) + k) % NCH;
                for (int j = 0; j < NCH; j++) begin
                    if (j == cand && in_valid[j]) begin
                        grant     = CHW'(j);
                        grant_vld = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        sel_data = '0;
        for (int i = 0; i < NCH; i++) begin
            in_ready[i] = rst_n && grant_vld && can_load && (grant == CHW'(i));
            if (grant == CHW'(i))
                sel_data = in_data[i*WIDTH +: WIDTH];
        end
    end

    assign accept = |(in_ready & in_valid);
    assign rr_nxt = (grant == CHW'(NCH - 1)) ? '0 : grant + 1'b1;

    always_comb begin
        state_nxt = state;
        lock_nxt  = lock_ch;
        cnt_nxt   = burst_cnt;
        case (state)
            IDLE: begin
                if (accept && BURST > 1) begin
                    state_nxt = LOCKED;
                    lock_nxt  = grant;
                    cnt_nxt   = CNTW'(BURST - 1);
                end
            end
            LOCKED: begin
                if (accept) begin
                    cnt_nxt = burst_cnt - 1'b1;
                    if (burst_cnt == CNTW'(1))
                        state_nxt = IDLE;
                end else if (can_load) begin
                    // Locked source went idle while the output could take a beat.
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lock_ch   <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            lock_ch   <= lock_nxt;
            burst_cnt <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_ch    <= grant;
            rr_ptr    <= rr_nxt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_chan_arb_mux.sv
// Bench for chan_arb_mux: five configurations share one stimulus stream and are checked every
// cycle against a behavioural model, plus directed literal expectations for each scenario.
module tb_chan_arb_mux;

    localparam int NI = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic [3:0]  rdy [NI];
    logic        ov  [NI];
    logic [7:0]  od  [NI];
    logic [1:0]  oc  [NI];
    logic        dbg [NI];
    logic [2:0]  rdy3;
    logic        rdy4;
    logic        oc4;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance configs: 0 rr/4ch, 1 priority/4ch, 2 rr/4ch/burst3, 3 rr/3ch, 4 single channel
    int cfg_nch   [NI] = '{4, 4, 4, 3, 1};
    int cfg_mode  [NI] = '{0, 1, 0, 0, 0};
    int cfg_burst [NI] = '{1, 1, 3, 1, 1};

    bit         m_ov    [NI];
    logic [7:0] m_od    [NI];
    int         m_oc    [NI];
    int         m_next  [NI];
    bit         m_lock  [NI];
    int         m_owner [NI];
    int         m_left  [NI];

    always #5 clk = ~clk;

    assign rdy[3] = {1'b0, rdy3};
    assign rdy[4] = {3'b000, rdy4};
    assign oc[4]  = {1'b0, oc4};

    chan_arb_mux #(.WIDTH(8), .NCH(4), .ARB_MODE(0), .BURST(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy[0]),
        .out_valid(ov[0]), .out_data(od[0]), .out_ch(oc[0]), .out_ready(out_ready), .dbg_state(dbg[0]));
    chan_arb_mux #(.WIDTH(8), .NCH(4), .ARB_MODE(1), .BURST(1)) u_pri (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy[1]),
        .out_valid(ov[1]), .out_data(od[1]), .out_ch(oc[1]), .out_ready(out_ready), .dbg_state(dbg[1]));
    chan_arb_mux #(.WIDTH(8), .NCH(4), .ARB_MODE(0), .BURST(3)) u_bst (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy[2]),
        .out_valid(ov[2]), .out_data(od[2]), .out_ch(oc[2]), .out_ready(out_ready), .dbg_state(dbg[2]));
    chan_arb_mux #(.WIDTH(8), .NCH(3), .ARB_MODE(0), .BURST(1)) u_n3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2:0]), .in_data(in_data[23:0]), .in_ready(rdy3),
        .out_valid(ov[3]), .out_data(od[3]), .out_ch(oc[3]), .out_ready(out_ready), .dbg_state(dbg[3]));
    chan_arb_mux #(.WIDTH(8), .NCH(1), .ARB_MODE(0), .BURST(1)) u_n1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0:0]), .in_data(in_data[7:0]), .in_ready(rdy4),
        .out_valid(ov[4]), .out_data(od[4]), .out_ch(oc4), .out_ready(out_ready), .dbg_state(dbg[4]));

    // Channel that owns the grant this cycle, or -1 when nobody is asking.
    function automatic int owner_of(input int k);
        int c;
        if (m_lock[k])
            return m_owner[k];
        for (int n = 0; n < cfg_nch[k]; n++) begin
            c = (cfg_mode[k] == 1) ? n : (m_next[k] + n) % cfg_nch[k];
            if (in_valid[c])
                return c;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready(input int k);
        int g;
        g = owner_of(k);
        if (!rst_n || g < 0 || (m_ov[k] && !out_ready))
            return 4'b0000;
        return 4'(1 << g);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < NI; k++) begin
            if (!rst_n) begin
                m_ov[k]    <= 1'b0;
                m_od[k]    <= 8'h00;
                m_oc[k]    <= 0;
                m_next[k]  <= 0;
                m_lock[k]  <= 1'b0;
                m_owner[k] <= 0;
                m_left[k]  <= 0;
            end else if (owner_of(k) >= 0 && (!m_ov[k] || out_ready) && in_valid[owner_of(k)]) begin
                m_ov[k]   <= 1'b1;
                m_od[k]   <= in_data[owner_of(k)*8 +: 8];
                m_oc[k]   <= owner_of(k);
                m_next[k] <= (owner_of(k) + 1) % cfg_nch[k];
                if (cfg_burst[k] > 1) begin
                    if (!m_lock[k]) begin
                        m_lock[k]  <= 1'b1;
                        m_owner[k] <= owner_of(k);
                        m_left[k]  <= cfg_burst[k] - 1;
                    end else begin
                        m_left[k] <= m_left[k] - 1;
                        if (m_left[k] == 1)
                            m_lock[k] <= 1'b0;
                    end
                end
            end else begin
                if (out_ready)
                    m_ov[k] <= 1'b0;
                if (m_lock[k] && (!m_ov[k] || out_ready))
                    m_lock[k] <= 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d @%0t: got %0h expected %0h", nm, k, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            chk("out_valid", k, 32'(ov[k]), 32'(m_ov[k]));
            chk("out_data", k, 32'(od[k]), 32'(m_od[k]));
            chk("out_ch", k, 32'(oc[k]), m_oc[k]);
            chk("in_ready", k, 32'(rdy[k]), 32'(exp_ready(k)));
            chk("lock_state", k, 32'(dbg[k]), 32'(m_lock[k]));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [3:0] v, input logic r);
        in_valid  = v;
        out_ready = r;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 4'b0000;
        out_ready = 1'b0;
        in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        repeat (2) step();
        chk("rst_out_valid", 0, 32'(ov[0]), 0);
        chk("rst_out_data", 0, 32'(od[0]), 0);
        rst_n = 1'b1;

        // Round-robin fairness, burst grouping and 3-channel rotation from one stream
        drive(4'b1111, 1'b1);
        for (int b = 0; b < 8; b++) begin
            step();
            chk("rr_ch", 0, 32'(oc[0]), b % 4);
            chk("rr_data", 0, 32'(od[0]), 8'hA0 + b % 4);
            chk("burst_ch", 2, 32'(oc[2]), (b / 3) % 4);
            chk("rr3_ch", 3, 32'(oc[3]), b % 3);
            chk("pri_ch", 1, 32'(oc[1]), 0);
        end

        // Sparse grant with rr_ptr at 2 on the 3-channel instance
        drive(4'b0010, 1'b1);
        step();
        chk("sparse_ch", 3, 32'(oc[3]), 1);
        chk("sparse_data", 3, 32'(od[3]), 8'hA1);
        drive(4'b0111, 1'b1);
        #1;
        chk("sparse_ptr_ready", 3, 32'(rdy[3]), 4'b0100);
        step();
        chk("sparse_next_ch", 3, 32'(oc[3]), 2);

        // Asynchronous reset with a beat pending
        drive(4'b0001, 1'b0);
        step();
        chk("pre_rst_valid", 0, 32'(ov[0]), 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 0, 32'(ov[0]), 0);
        chk("async_rst_data", 0, 32'(od[0]), 0);
        chk("async_rst_ready", 0, 32'(rdy[0]), 0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("release_ready", 0, 32'(rdy[0]), 4'b0001);
        step();
        chk("first_accept_valid", 0, 32'(ov[0]), 1);
        chk("first_accept_data", 0, 32'(od[0]), 8'hA0);

        // Backpressure holds the registered beat
        in_data[7:0] = 8'h5C;
        drive(4'b0001, 1'b1);
        step();
        chk("bp_load", 0, 32'(od[0]), 8'h5C);
        drive(4'b0001, 1'b0);
        in_data[7:0] = 8'h11;
        repeat (5) begin
            step();
            chk("bp_hold_data", 0, 32'(od[0]), 8'h5C);
            chk("bp_hold_valid", 0, 32'(ov[0]), 1);
            chk("bp_ready_low", 0, 32'(rdy[0]), 0);
        end
        drive(4'b0001, 1'b1);
        #1;
        chk("bp_ready_back", 0, 32'(rdy[0]), 4'b0001);
        step();
        chk("bp_next_beat", 0, 32'(od[0]), 8'h11);

        // Fixed priority: ch1 beats ch3 until it drops
        in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        drive(4'b1010, 1'b1);
        repeat (3) begin
            step();
            chk("prio_low_wins", 1, 32'(oc[1]), 1);
        end
        drive(4'b1000, 1'b1);
        step();
        chk("prio_ch3", 1, 32'(oc[1]), 3);
        chk("prio_ch3_data", 1, 32'(od[1]), 8'hA3);

        // Burst lock from a clean start, then early release
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        drive(4'b0101, 1'b1);
        for (int b = 0; b < 6; b++) begin
            step();
            chk("burst_seq", 2, 32'(oc[2]), (b < 3) ? 0 : 2);
        end
        step();
        chk("burst_relock_ch", 2, 32'(oc[2]), 0);
        chk("burst_locked", 2, 32'(dbg[2]), 1);
        drive(4'b0100, 1'b1);
        step();
        chk("early_release_idle_beat", 2, 32'(ov[2]), 0);
        chk("early_release_state", 2, 32'(dbg[2]), 0);
        step();
        chk("early_release_ch2", 2, 32'(oc[2]), 2);
        chk("early_release_valid", 2, 32'(ov[2]), 1);

        // Mixed valid/backpressure pattern exercised only against the model
        for (int i = 0; i < 40; i++) begin
            in_data = {8'(i * 4 + 3), 8'(i * 4 + 2), 8'(i * 4 + 1), 8'(i * 4)};
            drive(4'((i * 7 + 3) % 16), (i % 3) != 0);
            step();
        end
        drive(4'b0000, 1'b1);
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
